// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared, output-registered ALU.
// A request is accepted in IDLE or RESP, issued for one cycle in ISSUE,
// and its result is returned in RESP. Build option ALU_ARB_RR_EN selects
// round-robin arbitration. When it is undefined, port 0 has fixed priority.
//
// state | meaning
// IDLE  | no operation in flight, may accept a request
// ISSUE | captured operation presented to ALU with alu_EX=1
// RESP  | ALU result returned to owner, may accept the next request
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  I0,
  input  logic [3:0]  I1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res,
  output logic        carry,
  output logic        z,
  output logic [3:0]  alu_I,
  output logic        alu_EX,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_res,
  input  logic        alu_carry,
  input  logic        alu_z,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   win;
  logic   accept;

`ifdef ALU_ARB_RR_EN
  logic   last;

  // Round-robin winner: on a tie, grant the port not served last.
  always_comb begin
    win = req1;
    if (req0 && req1) win = !last;
  end
`else
  // Fixed priority winner: port 0 beats port 1.
  always_comb begin
    win = !req0;
  end
`endif

  // Next state, grants, done routing and ALU strobe; reset masks everything.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    alu_EX    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        alu_EX    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        done0 = !owner;
        done1 = owner;
        if (req0 || req1) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      gnt0 = !win;
      gnt1 = win;
    end
    if (rst) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      alu_EX    = 1'b0;
    end
  end

  // Result bus is qualified by done and otherwise held at zero.
  always_comb begin
    busy  = (state != IDLE) && !rst;
    res   = 32'd0;
    carry = 1'b0;
    z     = 1'b0;
    if (done0 || done1) begin
      res   = alu_res;
      carry = alu_carry;
      z     = alu_z;
    end
  end

  // State register, operand capture at accept, and owner tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      alu_I   <= 4'd0;
      alu_op1 <= 32'd0;
      alu_op2 <= 32'd0;
      owner   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last    <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner   <= win;
        alu_I   <= win ? I1 : I0;
        alu_op1 <= win ? a1 : a0;
        alu_op2 <= win ? b1 : b0;
`ifdef ALU_ARB_RR_EN
        last    <= win;
`endif
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports req0/req1  input  1  requester N wants an ALU operation.
REQ-004 SHALL have ports I0/I1  input  4  requester N ALU opcode (ALU encoding 1..13).
REQ-005 SHALL have ports a0/a1, b0/b1  input  32  requester N operands op1/op2.
REQ-006 SHALL have ports gnt0/gnt1  output  1  request N accepted this cycle (Mealy).
REQ-007 SHALL have ports done0/done1  output  1  one-cycle pulse, result for requester N valid.
REQ-008 SHALL have ports res  output 32, carry  output 1, z  output 1  shared result bus, qualified by done0/done1.
REQ-009 SHALL have ports alu_I  output 4, alu_EX  output 1, alu_op1/alu_op2  output 32  drive to ALU.
REQ-010 SHALL have ports alu_res  input 32, alu_carry  input 1, alu_z  input 1  registered ALU outputs.
REQ-011 SHALL have port busy  output 1  high when state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, ISSUE, RESP.
REQ-013 Accept cycle: in IDLE or RESP, if req0|req1, SHALL assert gnt of the winner only, capture its I/a/b into alu_I/alu_op1/alu_op2 registers at the edge, go to ISSUE.
REQ-014 IDLE with no request SHALL stay IDLE; RESP with no request SHALL go to IDLE.
REQ-015 ISSUE SHALL last exactly one cycle with alu_EX=1, then go to RESP; alu_EX SHALL be 0 in all other states.
REQ-016 RESP SHALL pulse done of the owning port for exactly one cycle with res=alu_res, carry=alu_carry, z=alu_z (combinational passthrough).
REQ-017 Latency: gnt in cycle N -> alu_EX in N+1 -> done in N+2; back-to-back throughput one operation per 2 cycles (new grant allowed in the RESP cycle).
REQ-018 gnt0 and gnt1 SHALL never be high together; done0 and done1 SHALL never be high together.
REQ-019 Requester SHALL hold req and operands until gnt; after gnt it may change them; captured values SHALL be unaffected.
REQ-020 Opcodes outside 1..13 SHALL be issued unchanged (ALU returns 0, z=1); arbiter performs no decode.
REQ-021 alu_I/alu_op1/alu_op2 SHALL hold their last captured values outside accept edges.
REQ-022 Owner tag SHALL be registered at accept and used for done routing; requests arriving in ISSUE SHALL wait (no gnt).
REQ-023 res/carry/z SHALL be 0 when neither done is high.

Reset
REQ-024 rst SHALL force state IDLE, gnt/done/alu_EX/busy 0, alu_I=0, alu_op1=alu_op2=0, last-served pointer=1 (port 0 preferred next).
REQ-025 rst asserted in ISSUE or RESP SHALL abort: no done pulse for the in-flight operation; rst has priority over any simultaneous request.

Configuration
REQ-026 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous req0&req1 grant the port not served last; pointer updates on every grant.
REQ-027 Macro ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins simultaneous requests; pointer logic absent.
REQ-028 Single requests SHALL be granted identically in both configurations.

Verification
REQ-029 req0=1, I0=1, a0=5, b0=7 from IDLE -> gnt0 cycle N, alu_EX=1/alu_I=1/alu_op1=5/alu_op2=7 cycle N+1, done0 cycle N+2 with res=12, z=0.
REQ-030 req0 and req1 held high for 4 operations (I0=3, I1=4) -> RR_EN: grants 0,1,0,1 every 2 cycles; without: grants 0,0,0,0, done1 never.
REQ-031 I0=2, a0=3, b0=3 -> done0 with res=0, z=1, carry=0; I0=2, a0=0, b0=1 -> res=32'hFFFFFFFF, carry=1.
REQ-032 rst pulsed in ISSUE cycle of an op -> no done pulse, alu_EX=0 next cycle, busy=0; next req1 granted normally.
REQ-033 req1 asserted during ISSUE of port-0 op -> gnt1 in the RESP cycle alongside done0; done1 two cycles later; gnt0/gnt1 never overlap.
REQ-034 I0=4'hF, a0=1, b0=1 -> issued unchanged, done0 with res=0, z=1.
